// File: rtl/alu_seq_if.sv
// alu_seq_if: start/operand/result bundle between the control unit and alu_seq.
// The control unit uses the master side; the ALU uses the slave side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             m;
    logic [3:0]       s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] t_hi;
    logic             cf;
    logic             zf;
    logic             nf;
    logic             busy;
    logic             done;

    modport master (
        output start, m, s, a, b,
        input  t, t_hi, cf, zf, nf, busy, done
    );

    modport slave (
        input  start, m, s, a, b,
        output t, t_hi, cf, zf, nf, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU behind a start/done handshake.
// Keeps the legacy m/s opcode map, adds carry-chained add/sub, OR/XOR and
// single-bit shifts. Flags cf/zf/nf persist until the next flag-updating op.
// Optional feature macro ALU_MUL_EN: compiles in a multi-cycle unsigned
// shift-add multiplier (s=1000) producing a 2*WIDTH-bit product on t_hi:t.
// Without it, s=1000 is a plain pass of a, busy and t_hi are tied to 0.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OP_ADC    = 4'b0001;
    localparam logic [3:0] OP_SBC    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_PASSB0 = 4'b0100;
    localparam logic [3:0] OP_NOTB   = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_ADD    = 4'b1001;
    localparam logic [3:0] OP_PASSB1 = 4'b1010;
    localparam logic [3:0] OP_AND    = 4'b1011;
    localparam logic [3:0] OP_SHL    = 4'b1100;
    localparam logic [3:0] OP_SHR    = 4'b1101;
    localparam logic [3:0] OP_OR     = 4'b1110;

    // Architectural result and flag registers
    logic [WIDTH-1:0] r_t;
    logic             r_cf;
    logic             r_zf;
    logic             r_nf;
    logic             r_done;

    // Single-cycle result path
    logic             w_cin;
    logic             w_bin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_res_cf;
    logic             w_upd;

    // Carry/borrow-in comes from the flag as it stood before this edge.
    assign w_cin = (bus.s == OP_ADC) ? r_cf : 1'b0;
    assign w_bin = (bus.s == OP_SBC) ? r_cf : 1'b0;
    assign w_add = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, w_cin};
    // Top bit of the WIDTH+1 difference is the borrow: b < a + borrow-in.
    assign w_sub = {1'b0, bus.b} - {1'b0, bus.a} - {{WIDTH{1'b0}}, w_bin};

    // Decode the single-cycle function; w_upd marks ops that write cf/zf/nf.
    always_comb begin
        w_res    = bus.a;
        w_res_cf = r_cf;
        w_upd    = 1'b0;
        if (bus.m) begin
            case (bus.s)
                OP_ADD, OP_ADC: begin
                    w_res    = w_add[WIDTH-1:0];
                    w_res_cf = w_add[WIDTH];
                    w_upd    = 1'b1;
                end
                OP_SUB, OP_SBC: begin
                    w_res    = w_sub[WIDTH-1:0];
                    w_res_cf = w_sub[WIDTH];
                    w_upd    = 1'b1;
                end
                OP_AND:             w_res = bus.a & bus.b;
                OP_OR:              w_res = bus.a | bus.b;
                OP_XOR:             w_res = bus.a ^ bus.b;
                OP_NOTB:            w_res = ~bus.b;
                OP_PASSB0, OP_PASSB1: w_res = bus.b;
                OP_SHL: begin
                    w_res    = {bus.b[WIDTH-2:0], 1'b0};
                    w_res_cf = bus.b[WIDTH-1];
                    w_upd    = 1'b1;
                end
                OP_SHR: begin
                    w_res    = {1'b0, bus.b[WIDTH-1:1]};
                    w_res_cf = bus.b[0];
                    w_upd    = 1'b1;
                end
                default:            w_res = bus.a;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int         CNT_W  = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_t_hi;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic               w_is_mul;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_pp;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;

    assign w_is_mul = bus.m && (bus.s == OP_MUL);
    assign w_accept = bus.start && (r_state == ST_IDLE);
    // Partial product for multiplier bit r_cnt; r_mplier[0] holds that bit.
    assign w_pp     = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_prod   = r_acc + w_pp;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiplier datapath: bit 0 is folded in on the accept edge, so only
    // WIDTH-1 further iterations are needed in ST_MUL.
    always_ff @(posedge clk) begin
        if (w_accept && w_is_mul) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b >> 1;
            r_acc    <= bus.b[0] ? {{WIDTH{1'b0}}, bus.a} : '0;
        end else if (r_state == ST_MUL) begin
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_prod;
        end
    end

    // Control FSM with registered results, flags, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_t     <= '0;
            r_t_hi  <= '0;
            r_cf    <= 1'b0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                            r_cnt   <= CNT_W'(1);
                        end else begin
                            r_done <= 1'b1;
                            r_t    <= w_res;
                            r_t_hi <= '0;
                            if (w_upd) begin
                                r_cf <= w_res_cf;
                                r_zf <= (w_res == '0);
                                r_nf <= w_res[WIDTH-1];
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_t     <= w_prod[WIDTH-1:0];
                        r_t_hi  <= w_prod[2*WIDTH-1:WIDTH];
                        r_cf    <= (w_prod[2*WIDTH-1:WIDTH] != '0);
                        r_zf    <= (w_prod == '0);
                        r_nf    <= w_prod[2*WIDTH-1];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.t_hi = r_t_hi;
    assign bus.busy = r_busy;
`else
    // Every op completes in one cycle: latch result and pulse done on start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_t    <= '0;
            r_cf   <= 1'b0;
            r_zf   <= 1'b0;
            r_nf   <= 1'b0;
        end else begin
            r_done <= bus.start;
            if (bus.start) begin
                r_t <= w_res;
                if (w_upd) begin
                    r_cf <= w_res_cf;
                    r_zf <= (w_res == '0);
                    r_nf <= w_res[WIDTH-1];
                end
            end
        end
    end

    assign bus.t_hi = '0;
    assign bus.busy = 1'b0;
`endif

    assign bus.t    = r_t;
    assign bus.cf   = r_cf;
    assign bus.zf   = r_zf;
    assign bus.nf   = r_nf;
    assign bus.done = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq, WIDTH=8.
// Multiplier vectors are compiled in when ALU_MUL_EN is defined.
module tb_alu_seq;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   busy_seen;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count any cycle with busy high (must never happen without the multiplier).
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] et, input logic [7:0] ehi,
                            input logic ecf, input logic ezf, input logic enf);
        chk({tag, ".t"},    32'(bus.t),    32'(et));
        chk({tag, ".t_hi"}, 32'(bus.t_hi), 32'(ehi));
        chk({tag, ".cf"},   32'(bus.cf),   32'(ecf));
        chk({tag, ".zf"},   32'(bus.zf),   32'(ezf));
        chk({tag, ".nf"},   32'(bus.nf),   32'(enf));
    endtask

    // Present one op for a single edge; outputs are examined 1 ns after it.
    task automatic issue(input logic im, input logic [3:0] is, input logic [7:0] ia, input logic [7:0] ib);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = im;
        bus.s     = is;
        bus.a     = ia;
        bus.b     = ib;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic im, input logic [3:0] is,
                          input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] et,
                          input logic ecf, input logic ezf, input logic enf);
        issue(im, is, ia, ib);
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk_outs(tag, et, 8'h00, ecf, ezf, enf);
    endtask

`ifdef ALU_MUL_EN
    // Multiply with done-latency and busy-width checks; optional stray start mid-op.
    task automatic run_mul(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic [7:0] et, input logic [7:0] ehi,
                           input logic ecf, input logic ezf, input logic enf, input bit poke);
        int lat;
        int nbusy;
        issue(1'b1, 4'b1000, ia, ib);
        lat   = 1;
        nbusy = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy === 1'b1) nbusy++;
            if (poke && lat == 3) begin
                bus.start = 1'b1;
                bus.m     = 1'b1;
                bus.s     = 4'b1001;
                bus.a     = 8'h01;
                bus.b     = 8'h01;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        chk({tag, ".busy_cycles"}, 32'(nbusy), 32'd7);
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        chk_outs(tag, et, ehi, ecf, ezf, enf);
        @(posedge clk);
        #1;
        chk({tag, ".done_once"}, 32'(bus.done), 32'd0);
        chk({tag, ".t_hold"}, 32'(bus.t_hi), 32'(ehi));
    endtask
`endif

    initial begin
        int ndone;
        n_chk     = 0;
        n_err     = 0;
        busy_seen = 0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.m     = 1'b0;
        bus.s     = 4'h0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry-out, then done must drop and t must hold
        run_op("add_f0_20", 1'b1, 4'b1001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("add_f0_20.done_drop", 32'(bus.done), 32'd0);
        chk("add_f0_20.t_hold", 32'(bus.t), 32'h10);

        // Subtract / borrow chain
        run_op("sub_5_5",  1'b1, 4'b0110, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op("sub_6_5",  1'b1, 4'b0110, 8'h06, 8'h05, 8'hFF, 1'b1, 1'b0, 1'b1);
        run_op("sbc_0_5",  1'b1, 4'b0010, 8'h00, 8'h05, 8'h04, 1'b0, 1'b0, 1'b0);

        // Carry out, logic op holds flags, ADC consumes carry
        run_op("add_ff_1", 1'b1, 4'b1001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op("and_hold", 1'b1, 4'b1011, 8'h0F, 8'h3C, 8'h0C, 1'b1, 1'b1, 1'b0);
        run_op("adc_1_1",  1'b1, 4'b0001, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0);

        // Shifts
        run_op("shl_81",   1'b1, 4'b1100, 8'h00, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0);
        run_op("shl_40",   1'b1, 4'b1100, 8'h00, 8'h40, 8'h80, 1'b0, 1'b0, 1'b1);
        run_op("shr_01",   1'b1, 4'b1101, 8'h00, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);

        // Logic and pass ops leave cf=1, zf=1, nf=0 untouched
        run_op("or",       1'b1, 4'b1110, 8'h0F, 8'h30, 8'h3F, 1'b1, 1'b1, 1'b0);
        run_op("xor",      1'b1, 4'b0011, 8'hFF, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
        run_op("notb",     1'b1, 4'b0101, 8'h11, 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
        run_op("passb_a",  1'b1, 4'b1010, 8'h11, 8'h77, 8'h77, 1'b1, 1'b1, 1'b0);
        run_op("passb_4",  1'b1, 4'b0100, 8'h11, 8'h66, 8'h66, 1'b1, 1'b1, 1'b0);
        run_op("m0_add",   1'b0, 4'b1001, 8'h12, 8'h34, 8'h12, 1'b1, 1'b1, 1'b0);
        run_op("m0_sub",   1'b0, 4'b0110, 8'h9A, 8'h34, 8'h9A, 1'b1, 1'b1, 1'b0);
        run_op("dflt_0",   1'b1, 4'b0000, 8'hAB, 8'h34, 8'hAB, 1'b1, 1'b1, 1'b0);
        run_op("dflt_7",   1'b1, 4'b0111, 8'hCD, 8'h34, 8'hCD, 1'b1, 1'b1, 1'b0);
        run_op("dflt_f",   1'b1, 4'b1111, 8'hEF, 8'h34, 8'hEF, 1'b1, 1'b1, 1'b0);

`ifdef ALU_MUL_EN
        // 0x10*0x20 = 0x0200 with a stray start while busy
        run_mul("mul_10_20", 8'h10, 8'h20, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
        // 0x00*0x5A = 0, 0xFF*0xFF = 0xFE01
        run_mul("mul_0_5a",  8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        run_mul("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
        // Non-multiply op after a multiply clears t_hi
        run_op("add_after_mul", 1'b1, 4'b1001, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
        run_mul("mul_ff_ff2", 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a multiply: abandoned, no done
        issue(1'b1, 4'b1000, 8'h10, 8'h20);
        chk("rstmul.busy_on", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rstmul", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rstmul.busy", 32'(bus.busy), 32'd0);
        chk("rstmul.done", 32'(bus.done), 32'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        chk("rstmul.no_done", 32'(ndone), 32'd0);
        run_op("add_after_rst", 1'b1, 4'b1001, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0);
`else
        // Without the multiplier, s=1000 is a single-cycle pass of a
        run_op("nomul_1000", 1'b1, 4'b1000, 8'h5A, 8'h33, 8'h5A, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("nomul.done_drop", 32'(bus.done), 32'd0);
        chk("nomul.busy_never", 32'(busy_seen), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the CPU's 8-bit combinational ALU. It takes WIDTH-bit operands and keeps the existing m/s opcode map, adding carry-chained ops, OR/XOR and shifts. Results and flags are registered behind a start/done handshake. An optional multi-cycle shift-add multiplier can be compiled in. It sits between the register file and the writeback mux of the datapath; the control unit owns start/busy.

## Interface
- WIDTH, 8: operand and result width (≥4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sample a, b, m, s and begin an operation; ignored while busy=1.
- m  in  1  1 = ALU function per s; 0 = pass a.
- s  in  4  function select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- t  out  WIDTH  registered result (low half for multiply).
- t_hi  out  WIDTH  high half of product; 0 for all other ops.
- cf  out  1  carry/borrow flag (registered, persistent).
- zf  out  1  zero flag (registered, persistent).
- nf  out  1  negative flag = t[WIDTH-1] of last flag-updating op.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: t/t_hi/flags valid for the op just finished.

## Operation
- States: IDLE, MUL. IDLE→MUL on start with a multiply opcode; MUL→IDLE after WIDTH iterations. All other ops complete from IDLE in one cycle.
- Function map (m=1):
  - 1001: ADD t=a+b.
  - 0001: ADC t=a+b+cf.
  - 0110: SUB t=b−a.
  - 0010: SBC t=b−a−cf.
  - 1011: AND.
  - 1110: OR.
  - 0011: XOR.
  - 0101: t=~b.
  - 1010 and 0100: t=b.
  - 1100: SHL t=b<<1, cf=b[MSB].
  - 1101: SHR t=b>>1, cf=b[0].
  - 1000: MUL t_hi:t=a*b (unsigned).
  - Any other s: t=a.
- m=0: t=a.
- Arithmetic is computed at WIDTH+1 bits. cf = bit WIDTH for add. For subtract, cf = borrow (1 when the minuend is less than the subtrahend plus borrow-in).
- Flag update rules:
  - ADD/ADC/SUB/SBC/SHL/SHR update cf, zf, nf; zf = (t==0).
  - MUL: cf = (t_hi≠0), zf = (full 2·WIDTH product == 0), nf = t_hi[MSB].
  - Logic and pass ops update t only; cf, zf, nf hold.
- ADC/SBC use cf as it was before the start edge.
- MUL: operands are latched at start; unsigned shift-add, one multiplier bit per cycle, LSB first.
- start while busy=1 is ignored: no latch, no done, flags untouched.

## Timing
- Reset (async, any state): t=0, t_hi=0, cf=0, zf=0, nf=0, busy=0, done=0, state=IDLE. A multiply in flight is abandoned with no done.
- Single-cycle op, start sampled at edge N: results valid and done=1 after edge N+1, for exactly one cycle.
- MUL, start sampled at edge N:
  - busy=1 after edge N+1 through edge N+WIDTH−1.
  - busy=0 and done=1 after edge N+WIDTH; t, t_hi, flags update on that same edge.
- start may be asserted in the same cycle as done; a new op is accepted back-to-back, giving single-cycle throughput of 1 op/cycle.
- t and t_hi hold their value between operations; done is never asserted without a completed op.

## Configuration
- ALU_MUL_EN defined: MUL state, product datapath and t_hi logic present, as described above.
- ALU_MUL_EN undefined:
  - s=1000 decodes as default pass (t=a), single-cycle, flags hold.
  - t_hi tied to 0, busy tied to 0.
  - No MUL state exists.

## Test plan
- WIDTH=8. ADD a=0xF0, b=0x20 → t=0x10, cf=1, zf=0, nf=0, done one cycle after start.
- SUB a=0x05, b=0x05 → t=0x00, cf=0, zf=1. Then SUB a=0x06, b=0x05 → t=0xFF, cf=1, nf=1. Then SBC a=0x00, b=0x05 → t=0x04.
- ADD 0xFF+0x01 (cf=1, zf=1), then AND a=0x0F, b=0x3C → t=0x0C with cf=1, zf=1 held. Then ADC a=0x01, b=0x01 → t=0x03, cf=0.
- ALU_MUL_EN: MUL a=0x10, b=0x20 → busy high for 7 cycles, done at start+8, t=0x00, t_hi=0x02, cf=1, zf=0. A start pulse mid-op is ignored.
- ALU_MUL_EN: rst_n low at start+3 of a MUL → all outputs 0 immediately, no done. The next ADD after reset release completes normally.
- ALU_MUL_EN undefined: m=1, s=1000, a=0x5A, b=0x33 → t=0x5A, t_hi=0, busy never high, done at start+1. With m=0, any s → t=a.
